// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin burst arbiter for the shared VGA plot port.
// Define PLOT_CLIP_EN to drop off-screen pixels and count them on clip_cnt.
module vga_plot_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1023,
  parameter int SCR_W   = 320,
  parameter int SCR_H   = 240
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   pix_valid,
  input  logic [NREQ-1:0]   pix_last,
  input  logic [9*NREQ-1:0] pix_x,
  input  logic [8*NREQ-1:0] pix_y,
  input  logic [12*NREQ-1:0] pix_c,
  output logic [NREQ-1:0]   gnt,
  output logic [8:0]        x,
  output logic [7:0]        y,
  output logic [11:0]       c,
  output logic              plot,
  output logic [16:0]       bback_addr,
  output logic              busy,
  output logic              timeout
`ifdef PLOT_CLIP_EN
  ,
  output logic [7:0]        clip_cnt
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [16:0] W17 = 17'(SCR_W);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [NREQ-1:0] gnt_d;
  logic [PW-1:0]  gidx_q;
  logic [PW-1:0]  gidx_d;
  logic [PW-1:0]  ptr_q;
  logic [PW-1:0]  ptr_d;
  logic [PW-1:0]  nxt_ptr;
  logic [WW-1:0]  wd_q;
  logic [WW-1:0]  wd_d;
  logic           to_d;

  logic [PW-1:0]  win;
  logic [NREQ-1:0] win_oh;

  logic [8:0]     sel_x;
  logic [7:0]     sel_y;
  logic [11:0]    sel_c;
  logic           sel_l;
  logic           sel_r;
  logic           accept;
  logic           expire;
  logic           oob;

  // Lowest set bit overall, overridden by the lowest set bit at/after ptr.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = PW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (PW'(i) >= ptr_q)) win = PW'(i);
    end
    win_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i] = (win == PW'(i));
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_c = '0;
    sel_l = 1'b0;
    sel_r = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == PW'(i)) begin
        sel_x = pix_x[i*9 +: 9];
        sel_y = pix_y[i*8 +: 8];
        sel_c = pix_c[i*12 +: 12];
        sel_l = pix_last[i];
        sel_r = req[i];
      end
    end
  end

  assign accept  = (state_q == BURST) && |(gnt & pix_valid);
  assign expire  = !accept && (wd_q == WW'(TIMEOUT - 1));
  assign nxt_ptr = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
  assign busy    = (state_q == BURST);

`ifdef PLOT_CLIP_EN
  assign oob = (int'(sel_x) >= SCR_W) || (int'(sel_y) >= SCR_H);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BURST;
          gnt_d   = win_oh;
          gidx_d  = win;
          wd_d    = '0;
        end
      end
      BURST: begin
        wd_d = accept ? '0 : wd_q + WW'(1);
        if ((accept && sel_l) || !sel_r || expire) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          to_d    = expire;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt     <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      timeout <= to_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x          <= '0;
      y          <= '0;
      c          <= '0;
      bback_addr <= '0;
      plot       <= 1'b0;
    end else begin
      plot <= 1'b0;
      if (accept && !oob) begin
        x          <= sel_x;
        y          <= sel_y;
        c          <= sel_c;
        bback_addr <= 17'(sel_y) * W17 + 17'(sel_x);
        plot       <= 1'b1;
      end
    end
  end

`ifdef PLOT_CLIP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_cnt <= '0;
    end else if (accept && oob && (clip_cnt != 8'hFF)) begin
      clip_cnt <= clip_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed and random checks of vga_plot_arbiter
// against a transaction-level reference model.
module tb_vga_plot_arbiter;

  localparam int NREQ = 3;
  localparam int TO   = 1023;

  logic         clk = 1'b0;
  logic         resetn;
  logic [2:0]   req;
  logic [2:0]   pix_valid;
  logic [2:0]   pix_last;
  logic [26:0]  pix_x;
  logic [23:0]  pix_y;
  logic [35:0]  pix_c;
  logic [2:0]   gnt;
  logic [8:0]   x;
  logic [7:0]   y;
  logic [11:0]  c;
  logic         plot;
  logic [16:0]  bback_addr;
  logic         busy;
  logic         timeout;
`ifdef PLOT_CLIP_EN
  logic [7:0]   clip_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state: owner = -1 when nobody holds the port
  int m_owner, m_ptr, m_silent, m_clip;
  int m_x, m_y, m_c, m_addr;
  bit m_plot, m_to;

  always #5 clk = ~clk;

  vga_plot_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TO), .SCR_W(320), .SCR_H(240)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req),
    .pix_valid(pix_valid), .pix_last(pix_last),
    .pix_x(pix_x), .pix_y(pix_y), .pix_c(pix_c),
    .gnt(gnt), .x(x), .y(y), .c(c), .plot(plot),
    .bback_addr(bback_addr), .busy(busy), .timeout(timeout)
`ifdef PLOT_CLIP_EN
    , .clip_cnt(clip_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_silent = 0; m_clip = 0;
    m_x = 0; m_y = 0; m_c = 0; m_addr = 0;
    m_plot = 0; m_to = 0;
  endtask

  task automatic model_step();
    int g, px, py, pc, k;
    bit done, clip;
    m_plot = 0;
    m_to = 0;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      for (int n = 0; n < NREQ; n++) begin
        k = (m_ptr + n) % NREQ;
        if (req[k] && m_owner < 0) m_owner = k;
      end
      m_silent = 0;
    end else begin
      g = m_owner;
      done = 0;
      if (pix_valid[g]) begin
        px = int'(pix_x[g*9 +: 9]);
        py = int'(pix_y[g*8 +: 8]);
        pc = int'(pix_c[g*12 +: 12]);
        m_silent = 0;
        clip = 0;
`ifdef PLOT_CLIP_EN
        clip = (px >= 320) || (py >= 240);
`endif
        if (clip) begin
          if (m_clip < 255) m_clip++;
        end else begin
          m_x = px; m_y = py; m_c = pc;
          m_addr = py * 320 + px;
          m_plot = 1;
        end
        if (pix_last[g]) done = 1;
      end else begin
        m_silent++;
        if (m_silent == TO) begin
          done = 1;
          m_to = 1;
        end
      end
      if (!req[g]) done = 1;
      if (done) begin
        m_owner = -1;
        m_ptr = (g + 1) % NREQ;
      end
    end
  endtask

  task automatic check_all();
    logic [2:0] eg;
    eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("x", 32'(x), m_x);
    chk("y", 32'(y), m_y);
    chk("c", 32'(c), m_c);
    chk("plot", 32'(plot), 32'(m_plot));
    chk("bback_addr", 32'(bback_addr), m_addr);
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
`ifdef PLOT_CLIP_EN
    chk("clip_cnt", 32'(clip_cnt), m_clip);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_pix(input int i, input int px, input int py,
                         input int pc, input bit v, input bit l);
    pix_x[i*9 +: 9]   = 9'(px);
    pix_y[i*8 +: 8]   = 8'(py);
    pix_c[i*12 +: 12] = 12'(pc);
    pix_valid[i] = v;
    pix_last[i]  = l;
  endtask

  task automatic clear_in();
    req = '0; pix_valid = '0; pix_last = '0;
    pix_x = '0; pix_y = '0; pix_c = '0;
  endtask

  initial begin
    logic [2:0] rr_exp [8];
    bit seen;
    int nto;
    rr_exp = '{3'b001, 3'b000, 3'b010, 3'b000,
               3'b100, 3'b000, 3'b001, 3'b000};

    resetn = 1'b0;
    clear_in();
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // round robin from pointer 0, one-pixel bursts
    req = 3'b111;
    set_pix(0, 1, 2, 'h001, 1, 1);
    set_pix(1, 3, 4, 'h002, 1, 1);
    set_pix(2, 5, 6, 'h003, 1, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(rr_exp[i]));
    end
    clear_in();
    tick();

    // single requester streaming three pixels
    req = 3'b010;
    tick();
    chk("single_gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 3; i++) begin
      set_pix(1, 10 + i, 20, 'hF00, 1, i == 2);
      tick();
      chk("single_plot", 32'(plot), 32'h1);
      chk("single_addr", 32'(bback_addr), 6410 + i);
    end
    chk("single_end_gnt", 32'(gnt), 32'h0);
    clear_in();
    tick();

    // non-granted noise on requester 2
    req = 3'b001;
    tick();
    set_pix(0, 30, 40, 'h0AB, 1, 0);
    set_pix(2, 5, 5, 'hFFF, 1, 0);
    tick();
    chk("noise_x", 32'(x), 32'd30);
    set_pix(0, 31, 40, 'h0AB, 1, 1);
    tick();
    chk("noise_x2", 32'(x), 32'd31);
    chk("noise_y", 32'(y), 32'd40);
    clear_in();
    tick();

    // request drop with a pixel at the screen corner
    req = 3'b100;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h4);
    req = 3'b000;
    set_pix(2, 319, 239, 'h123, 1, 0);
    tick();
    chk("drop_plot", 32'(plot), 32'h1);
    chk("drop_addr", 32'(bback_addr), 32'd76799);
    chk("drop_gnt0", 32'(gnt), 32'h0);
    clear_in();
    tick();

    // watchdog
    req = 3'b001;
    tick();
    seen = 0;
    nto = 0;
    for (int n = 1; n <= 1100 && !seen; n++) begin
      tick();
      if (timeout) begin
        seen = 1;
        nto = n;
      end
    end
    chk("wd_seen", 32'(seen), 32'h1);
    chk("wd_cycles", nto, TO);
    req = 3'b011;
    tick();
    chk("wd_next_gnt", 32'(gnt), 32'h2);
    chk("wd_pulse_gone", 32'(timeout), 32'h0);

    // asynchronous reset mid-burst
    set_pix(1, 50, 60, 'hABC, 1, 0);
    tick();
    chk("pre_rst_plot", 32'(plot), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_plot", 32'(plot), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    clear_in();
    resetn = 1'b1;
    req = 3'b110;
    tick();
    chk("arst_first_gnt", 32'(gnt), 32'h2);
`ifdef PLOT_CLIP_EN
    set_pix(1, 320, 0, 'h111, 1, 1);
    tick();
    chk("clip_plot", 32'(plot), 32'h0);
    chk("clip_cnt1", 32'(clip_cnt), 32'h1);
`endif
    clear_in();
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        req[i] = ($urandom_range(0, 9) < 8);
`ifdef PLOT_CLIP_EN
        set_pix(i, $urandom_range(0, 359), $urandom_range(0, 259),
                $urandom_range(0, 4095), $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) < 3);
`else
        set_pix(i, $urandom_range(0, 319), $urandom_range(0, 239),
                $urandom_range(0, 4095), $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) < 3);
`endif
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single VGA plot port (x, y, c, plot) and the background-ROM address path between NREQ drawing engines: player sprite movers, the score/dice datapath and the background restorer.
- Round-robin burst arbiter: a granted requester streams pixels until it marks the last one or drops its request.
- Registers the plot outputs and computes the background address (y*320 + x) alongside each pixel.
- Sits between the game control FSM's drawing engines and the VGA adapter.

Parameters:
- NREQ, 3, number of requesters (2..4)
- TIMEOUT, 1023, BURST cycles without an accepted pixel before the grant is revoked
- SCR_W, 320, screen width used in the address calculation and clipping
- SCR_H, 240, screen height used for clipping

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- req  in  NREQ  per-requester bus request, bit i = requester i
- pix_valid  in  NREQ  requester i presents a pixel this cycle
- pix_last  in  NREQ  presented pixel is the last of the burst
- pix_x  in  9*NREQ  packed x coordinates, slice i = [9i+8:9i]
- pix_y  in  8*NREQ  packed y coordinates
- pix_c  in  12*NREQ  packed 12-bit RGB colours
- gnt  out  NREQ  one-hot grant, registered
- x  out  9  plot x
- y  out  8  plot y
- c  out  12  plot colour
- plot  out  1  VGA write enable, one cycle per pixel
- bback_addr  out  17  background-ROM address y*SCR_W + x, aligned with x/y
- busy  out  1  high in BURST
- timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Clock is clk. Reset is resetn: asynchronous, active-low. While resetn=0, all outputs are 0, state is IDLE and the round-robin pointer is 0.
- States: IDLE, BURST.
- IDLE:
  - if any req bit is set, pick the first set bit at or after the pointer, wrapping modulo NREQ.
  - Next cycle: gnt = onehot(winner), busy = 1, state = BURST, watchdog counter = 0.
  - Grant latency is 1 cycle from req.
- BURST (granted index g):
  - A pixel is accepted when gnt[g] & pix_valid[g].
  - pix_valid on non-granted requesters is ignored. Those pixels are never plotted or queued.
- Accepted pixel timing:
  - Next cycle: x, y, c take slice g; bback_addr = y*SCR_W + x, computed at 17 bits with no truncation (max 76799); plot = 1.
  - Otherwise plot = 0 and x, y, c, bback_addr hold their last values.
  - Plot latency is exactly 1 cycle.
- Leaving BURST, taken next cycle, with gnt = 0, busy = 0, pointer = (g+1) mod NREQ, state = IDLE, on any of:
  - a pixel is accepted with pix_last[g] = 1; that pixel is still plotted.
  - req[g] = 0; any pix_valid[g] in that same cycle is still accepted.
  - the watchdog expires.
- A full IDLE cycle always separates two bursts, including a requester re-winning immediately.
- Watchdog:
  - Counts BURST cycles with no accepted pixel and clears on every accepted pixel.
  - When the count reaches TIMEOUT, the grant is revoked next cycle and timeout pulses for 1 cycle.
- Fairness: the requester just served has lowest priority in the next arbitration.
- Asserting resetn low mid-burst:
  - gnt, plot and busy drop immediately.
  - An in-flight registered pixel is discarded.
  - After release, arbitration restarts from requester 0.

Optional Feature:
- Macro: PLOT_CLIP_EN.
- Defined:
  - An accepted pixel with x >= SCR_W or y >= SCR_H still counts as accepted (watchdog clears, pix_last honoured), but plot stays 0 and x, y, c, bback_addr are not updated.
  - Adds output clip_cnt (8 bits), which counts clipped pixels, saturates at 255 and resets to 0.
- Not defined:
  - All accepted pixels are plotted unchanged.
  - bback_addr is computed from the raw coordinates.
  - clip_cnt port is absent.

Test Plan:
- Single requester: req[1]=1; stream 3 pixels (10,20,0xF00), (11,20,0xF00), (12,20,0xF00 last) -> gnt=3'b010 one cycle after req; plot high 3 consecutive cycles; bback_addr=6410,6411,6412; gnt=0 the cycle after the last pixel.
- Round robin: req=3'b111 held, each burst 1 pixel with last -> grant order 0,1,2,0 with one IDLE cycle between bursts.
- Non-granted noise: gnt[0] active, pix_valid[2]=1 with (5,5) -> no plot for requester 2; only requester 0 pixels appear on x/y.
- Request drop: requester 2 granted; drop req[2] with pix_valid[2]=1 at (319,239) -> pixel plotted with bback_addr=76799; gnt=0 next cycle.
- Watchdog: grant requester 0, hold pix_valid=0 for 1023 cycles -> timeout pulses once, gnt=0, next arbitration starts at requester 1.
- Async reset: resetn low mid-burst between clock edges -> gnt, plot, busy go 0 immediately; after release with req=3'b110 the first grant is requester 1. With PLOT_CLIP_EN: a pixel at (320,0) gives plot=0 and clip_cnt=1.
